// File: rtl/pmem_arbiter_if.sv
// pmem_arbiter_if
//   One cache-line physical-memory port: a read or write command with its
//   address and write line, answered by a one-cycle resp carrying the read line.
//   The same bundle describes both requester ports (I-cache, D-cache) and the
//   downstream memory port.
//
//   Signals
//     read    : line read request       (master -> slave)
//     write   : line write request      (master -> slave)
//     address : line address            (master -> slave)
//     wdata   : line to write           (master -> slave)
//     rdata   : line read back          (slave -> master)
//     resp    : transfer complete pulse (slave -> master)
//
//   Modports
//     master : the side issuing commands (cache controller, or the arbiter downstream)
//     slave  : the side answering them (the arbiter upstream, or memory)

interface pmem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
);
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [LINE_WIDTH-1:0] wdata;
    logic [LINE_WIDTH-1:0] rdata;
    logic                  resp;

    modport master (
        output read,
        output write,
        output address,
        output wdata,
        input  rdata,
        input  resp
    );

    modport slave (
        input  read,
        input  write,
        input  address,
        input  wdata,
        output rdata,
        output resp
    );
endinterface

// File: rtl/pmem_arbiter.sv
// pmem_arbiter
//   Shares one physical-memory port between the I-cache and the D-cache.
//   One requester is granted at a time; its command (op, address, write line)
//   is latched at grant and replayed downstream until memory answers, so the
//   requester's live inputs do not matter during service. Simultaneous
//   requests are resolved round-robin against the previous winner.
//
//   Ports
//     clk     : clock, all state changes on the rising edge
//     reset_n : asynchronous active-low reset
//     i_pmem  : I-cache request port (slave side)
//     d_pmem  : D-cache request port (slave side)
//     mem     : downstream memory port (master side)

module pmem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic          clk,
    input  logic          reset_n,
    pmem_arbiter_if.slave  i_pmem,
    pmem_arbiter_if.slave  d_pmem,
    pmem_arbiter_if.master mem
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    // last_grant encoding: 0 = I-cache, 1 = D-cache
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t                state_q,      state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  op_write_q,   op_write_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [LINE_WIDTH-1:0] wdata_q,      wdata_d;

    logic i_req;
    logic d_req;
    logic grant_i;
    logic grant_d;
    logic mem_read_c;
    logic mem_write_c;
    logic i_resp_c;
    logic d_resp_c;

    assign i_req = i_pmem.read | i_pmem.write;
    assign d_req = d_pmem.read | d_pmem.write;

    // On a tie the side that did not win last time gets the port.
    assign grant_i = i_req & (~d_req | (last_grant_q == GRANT_D));
    assign grant_d = d_req & (~i_req | (last_grant_q == GRANT_I));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_write_d   = op_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        i_resp_c     = 1'b0;
        d_resp_c     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // mem_resp is ignored here; only requests move the FSM.
                // A write wins if a requester raises read and write together.
                if (grant_i) begin
                    state_d      = SERVE_I;
                    last_grant_d = GRANT_I;
                    op_write_d   = i_pmem.write;
                    addr_d       = i_pmem.address;
                    wdata_d      = i_pmem.wdata;
                end else if (grant_d) begin
                    state_d      = SERVE_D;
                    last_grant_d = GRANT_D;
                    op_write_d   = d_pmem.write;
                    addr_d       = d_pmem.address;
                    wdata_d      = d_pmem.wdata;
                end
            end

            SERVE_I: begin
                mem_read_c  = ~op_write_q;
                mem_write_c = op_write_q;
                // Returning to IDLE forces one idle cycle, so a request still
                // held in the resp cycle is not re-granted as the same transfer.
                if (mem.resp) begin
                    i_resp_c = 1'b1;
                    state_d  = IDLE;
                end
            end

            SERVE_D: begin
                mem_read_c  = ~op_write_q;
                mem_write_c = op_write_q;
                if (mem.resp) begin
                    d_resp_c = 1'b1;
                    state_d  = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Reset leaves last_grant at D so the I-cache wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_D;
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_write_q   <= op_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign mem.read    = mem_read_c;
    assign mem.write   = mem_write_c;
    assign mem.address = addr_q;
    assign mem.wdata   = wdata_q;

    // Read data is broadcast to both caches; only resp selects the owner.
    assign i_pmem.rdata = mem.rdata;
    assign d_pmem.rdata = mem.rdata;
    assign i_pmem.resp  = i_resp_c;
    assign d_pmem.resp  = d_resp_c;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter
//   Self-checking bench for pmem_arbiter: a table of directed cycles with
//   hand-computed expectations, randomized traffic compared against a
//   transaction-level reference model, and hand-written multi-cycle sequences
//   for alternation, back-to-back transfers, mid-service changes and reset.

module tb_pmem_arbiter;

    localparam int AW = 16;
    localparam int LW = 128;

    localparam logic [LW-1:0] IWD = {8{16'h1111}};
    localparam logic [LW-1:0] DWD = {8{16'hD00D}};

    logic clk = 1'b0;
    logic reset_n;

    pmem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) i_if ();
    pmem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) d_if ();
    pmem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) m_if ();

    pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .i_pmem (i_if),
        .d_pmem (d_if),
        .mem    (m_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: which transaction owns the port, and what it asked for.
    bit            m_busy;
    bit            m_side;   // 0 = I, 1 = D
    bit            m_write;
    bit            m_last;   // side of the most recent grant
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    logic [LW-1:0] cur_rdata;

    typedef struct {
        logic          rst;
        logic          ir;
        logic          iw;
        logic [AW-1:0] ia;
        logic          dr;
        logic          dw;
        logic [AW-1:0] da;
        logic          mr;
        logic          e_rd;
        logic          e_wr;
        logic          e_chk;
        logic [AW-1:0] e_addr;
        logic [LW-1:0] e_wdata;
        logic          e_ir;
        logic          e_dr;
    } vec_t;

    vec_t vecs [12];

    task automatic checkValue(input string name, input logic [LW-1:0] actual, input logic [LW-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_busy  = 1'b0;
        m_side  = 1'b0;
        m_write = 1'b0;
        m_last  = 1'b1;
        m_addr  = '0;
        m_wdata = '0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic modelEdge();
        bit ireq;
        bit dreq;
        bit pick_d;
        if (m_busy) begin
            if (m_if.resp) m_busy = 1'b0;
        end else begin
            ireq = i_if.read | i_if.write;
            dreq = d_if.read | d_if.write;
            if (ireq || dreq) begin
                if (ireq && dreq) pick_d = (m_last == 1'b0);
                else              pick_d = dreq;
                m_busy  = 1'b1;
                m_side  = pick_d;
                m_last  = pick_d;
                m_write = pick_d ? d_if.write   : i_if.write;
                m_addr  = pick_d ? d_if.address : i_if.address;
                m_wdata = pick_d ? d_if.wdata   : i_if.wdata;
            end
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic iw, input logic [AW-1:0] ia, input logic [LW-1:0] iwd,
                                 input logic dr, input logic dw, input logic [AW-1:0] da, input logic [LW-1:0] dwd,
                                 input logic mr, input logic [LW-1:0] mrd);
        i_if.read    = ir;
        i_if.write   = iw;
        i_if.address = ia;
        i_if.wdata   = iwd;
        d_if.read    = dr;
        d_if.write   = dw;
        d_if.address = da;
        d_if.wdata   = dwd;
        m_if.resp    = mr;
        m_if.rdata   = mrd;
        cur_rdata    = mrd;
    endtask

    task automatic checkOutput();
        checkValue("mem_read",  m_if.read,  m_busy && !m_write);
        checkValue("mem_write", m_if.write, m_busy && m_write);
        if (m_busy) begin
            checkValue("mem_address", m_if.address, m_addr);
            checkValue("mem_wdata",   m_if.wdata,   m_wdata);
        end
        checkValue("i_pmem_resp",  i_if.resp,  m_busy && !m_side && m_if.resp);
        checkValue("d_pmem_resp",  d_if.resp,  m_busy && m_side && m_if.resp);
        checkValue("i_pmem_rdata", i_if.rdata, cur_rdata);
        checkValue("d_pmem_rdata", d_if.rdata, cur_rdata);
    endtask

    task automatic atNegedge();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic endCycle();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0, '0);
        modelReset();
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] randLine();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [LW-1:0] rd;
        logic          mr;
        int            grants;
        int            budget;
        int            phase;
        int            svc;
        int            gap;
        int            ntx;
        logic [AW-1:0] t_addr [2];
        logic          t_wr   [2];
        bit            busy;

        // Directed cycles: columns are rst, inputs, then expected outputs.
        vecs[0]  = '{0, 1,0,16'h1230, 0,0,16'h0000, 0,  0,0,0,16'h0000,'0,  0,0};
        vecs[1]  = '{0, 1,0,16'h1230, 0,0,16'h0000, 0,  1,0,1,16'h1230,IWD, 0,0};
        vecs[2]  = '{0, 1,0,16'h1230, 0,0,16'h0000, 0,  1,0,1,16'h1230,IWD, 0,0};
        vecs[3]  = '{0, 1,0,16'h1230, 0,0,16'h0000, 1,  1,0,1,16'h1230,IWD, 1,0};
        vecs[4]  = '{0, 0,0,16'h0000, 0,0,16'h0000, 1,  0,0,0,16'h0000,'0,  0,0};
        vecs[5]  = '{1, 0,0,16'h0000, 0,0,16'h0000, 0,  0,0,1,16'h0000,'0,  0,0};
        vecs[6]  = '{0, 1,0,16'h2000, 1,1,16'h4A70, 0,  0,0,0,16'h0000,'0,  0,0};
        vecs[7]  = '{0, 1,0,16'h2000, 1,1,16'h4A70, 0,  1,0,1,16'h2000,IWD, 0,0};
        vecs[8]  = '{0, 1,0,16'h2000, 1,1,16'h4A70, 1,  1,0,1,16'h2000,IWD, 1,0};
        vecs[9]  = '{0, 0,0,16'h0000, 1,1,16'h4A70, 0,  0,0,0,16'h0000,'0,  0,0};
        vecs[10] = '{0, 0,0,16'h0000, 1,1,16'h4A70, 1,  0,1,1,16'h4A70,DWD, 0,1};
        vecs[11] = '{0, 0,0,16'h0000, 0,0,16'h0000, 0,  0,0,0,16'h0000,'0,  0,0};

        doReset();

        for (int k = 0; k < 12; k++) begin
            rd = randLine();
            if (vecs[k].rst) begin
                reset_n = 1'b0;
                modelReset();
            end
            applyStimulus(vecs[k].ir, vecs[k].iw, vecs[k].ia, IWD,
                          vecs[k].dr, vecs[k].dw, vecs[k].da, DWD,
                          vecs[k].mr, rd);
            @(negedge clk);
            checkValue($sformatf("vec%0d mem_read", k),  m_if.read,  vecs[k].e_rd);
            checkValue($sformatf("vec%0d mem_write", k), m_if.write, vecs[k].e_wr);
            if (vecs[k].e_chk) begin
                checkValue($sformatf("vec%0d mem_address", k), m_if.address, vecs[k].e_addr);
                checkValue($sformatf("vec%0d mem_wdata", k),   m_if.wdata,   vecs[k].e_wdata);
            end
            checkValue($sformatf("vec%0d i_pmem_resp", k),  i_if.resp,  vecs[k].e_ir);
            checkValue($sformatf("vec%0d d_pmem_resp", k),  d_if.resp,  vecs[k].e_dr);
            checkValue($sformatf("vec%0d i_pmem_rdata", k), i_if.rdata, rd);
            checkValue($sformatf("vec%0d d_pmem_rdata", k), d_if.rdata, rd);
            if (vecs[k].rst) #1 reset_n = 1'b1;
            endCycle();
        end

        // Randomized traffic against the reference model.
        doReset();
        for (int c = 0; c < 400; c++) begin
            applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, AW'($urandom), randLine(),
                          $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, AW'($urandom), randLine(),
                          $urandom_range(0, 2) == 0, randLine());
            atNegedge();
            endCycle();
        end

        // Both sides requesting continuously: grants must alternate I, D, I, ...
        doReset();
        grants = 0;
        budget = 0;
        while (grants < 6 && budget < 60) begin
            mr = m_if.read | m_if.write;
            applyStimulus(1, 0, 16'h1000, IWD, 1, 0, 16'h2000, DWD, mr, randLine());
            if (mr) begin
                checkValue($sformatf("alternate grant %0d side", grants), m_if.address == 16'h2000, grants % 2);
                grants++;
            end
            atNegedge();
            endCycle();
            budget++;
        end
        checkValue("alternate grants within budget", grants, 6);

        // D writeback then D read, memory answering on the second service cycle.
        doReset();
        phase  = 0;
        svc    = 0;
        gap    = 0;
        ntx    = 0;
        budget = 0;
        while (phase < 2 && budget < 40) begin
            busy = m_if.read | m_if.write;
            if (busy && svc == 0 && ntx < 2) begin
                t_addr[ntx] = m_if.address;
                t_wr[ntx]   = m_if.write;
                ntx++;
            end
            if (!busy && phase == 1 && ntx == 1) gap++;
            mr = busy && (svc == 1);
            applyStimulus(0, 0, '0, IWD, phase == 1, phase == 0, (phase == 0) ? 16'h4A70 : 16'h2B30, DWD, mr, randLine());
            atNegedge();
            endCycle();
            if (mr) begin
                phase++;
                svc = 0;
            end else if (busy) begin
                svc++;
            end
            budget++;
        end
        checkValue("writeback/read transfers", ntx, 2);
        if (ntx == 2) begin
            checkValue("first transfer address",  t_addr[0], 16'h4A70);
            checkValue("first transfer is write", t_wr[0],   1'b1);
            checkValue("second transfer address", t_addr[1], 16'h2B30);
            checkValue("second transfer is read", t_wr[1],   1'b0);
        end
        checkValue("idle cycles between D transfers", gap, 1);

        // Granted requester changes everything mid-service.
        doReset();
        applyStimulus(1, 0, 16'h0ABC, IWD, 0, 0, '0, '0, 0, randLine());
        atNegedge();
        endCycle();
        applyStimulus(0, 1, 16'h5555, DWD, 0, 0, '0, '0, 0, randLine());
        atNegedge();
        checkValue("midservice address held", m_if.address, 16'h0ABC);
        checkValue("midservice op held",      m_if.read,    1'b1);
        checkValue("midservice wdata held",   m_if.wdata,   IWD);
        endCycle();
        applyStimulus(0, 0, 16'h7777, '0, 0, 0, '0, '0, 1, randLine());
        atNegedge();
        checkValue("midservice resp pulse", i_if.resp, 1'b1);
        endCycle();
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0, randLine());
        atNegedge();
        endCycle();

        // Reset arriving during SERVE_D, then a stray mem_resp.
        doReset();
        applyStimulus(0, 0, '0, '0, 0, 1, 16'h3C40, DWD, 0, randLine());
        atNegedge();
        endCycle();
        applyStimulus(0, 0, '0, '0, 0, 1, 16'h3C40, DWD, 0, randLine());
        atNegedge();
        endCycle();
        applyStimulus(0, 0, '0, '0, 0, 1, 16'h3C40, DWD, 1, randLine());
        #2 reset_n = 1'b0;
        modelReset();
        #1;
        checkValue("reset mem_read",    m_if.read,    1'b0);
        checkValue("reset mem_write",   m_if.write,   1'b0);
        checkValue("reset mem_address", m_if.address, '0);
        checkValue("reset mem_wdata",   m_if.wdata,   '0);
        checkValue("reset i_pmem_resp", i_if.resp,    1'b0);
        checkValue("reset d_pmem_resp", d_if.resp,    1'b0);
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 1, randLine());
        atNegedge();
        #1 reset_n = 1'b1;
        endCycle();
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 1, randLine());
        atNegedge();
        checkValue("post-reset stray resp d", d_if.resp, 1'b0);
        checkValue("post-reset stray resp i", i_if.resp, 1'b0);
        endCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
